axi_rd_arbiter: RTL and testbench

- Shares one AXI-lite read port (AR + R channels) to instruction/data memory between two requesters: IFU (master 0) and LSU (master 1).
- Sits between the fetch/load units and the memory model.
- Serialises transactions: one outstanding read total, owned by exactly one master from grant until the R handshake.

---
 rtl/axi_rd_arbiter_pkg.sv | 17 +
 rtl/axi_rd_arbiter_arb_pick_2.sv | 32 +++
 rtl/axi_rd_arbiter.sv | 131 +++++++++++++
 tb/tb_axi_rd_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// rtl/axi_rd_arbiter_pkg.sv - shared encodings for the two-master AXI-lite read arbiter
//   FSM state encoding, master IDs and AXI read-response codes.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  localparam logic MID_IFU = 1'b0;
  localparam logic MID_LSU = 1'b1;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_rd_arbiter_arb_pick_2.sv
// rtl/axi_rd_arbiter_arb_pick_2.sv - combinational 2-way request picker
//   Macro: AXI_RD_ARB_RR_EN selects round-robin tie-break; undefined gives LSU > IFU.
//   Ports:
//     req[1:0]    in   request vector, bit 0 = IFU, bit 1 = LSU
//     last_grant  in   master ID granted last (only consulted in round-robin mode)
//     winner      out  master ID to grant; only meaningful when req != 0
module arb_pick_2
  import axi_rd_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner
);

`ifdef AXI_RD_ARB_RR_EN
  // On a tie the master that did not win last time goes next; a lone
  // requester always wins.
  always_comb begin
    if (req == 2'b11) begin
      winner = ~last_grant;
    end else begin
      winner = req[1] ? MID_LSU : MID_IFU;
    end
  end
`else
  // Fixed priority: the LSU wins whenever it asks.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign winner = req[1] ? MID_LSU : MID_IFU;
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - shares one AXI-lite read port between IFU (m0) and LSU (m1)
//   Macro: AXI_RD_ARB_RR_EN enables round-robin arbitration (default: LSU > IFU).
//   One outstanding read total; the granted master owns it until the R handshake.
//   Ports:
//     clk, resetn                  clock, asynchronous active-low reset
//     m0_* / m1_*                  AR and R channels of IFU / LSU (slave side)
//       arvalid, araddr in; arready out; rvalid, rdata, rresp out; rready in
//     s_*                          AR and R channels toward memory (master side)
//       arvalid, araddr out; arready in; rvalid, rdata, rresp in; rready out
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              m0_arvalid,
  input  logic [ADDR_W-1:0] m0_araddr,
  output logic              m0_arready,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,

  input  logic              m1_arvalid,
  input  logic [ADDR_W-1:0] m1_araddr,
  output logic              m1_arready,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,

  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arready,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp
);

  arb_state_t state;
  logic       owner;
  logic       last_grant;
  logic       winner;
  logic [1:0] req;
  logic       grant;
  logic       in_addr;
  logic       in_data;

  assign req   = {m1_arvalid, m0_arvalid};
  assign grant = (state == ST_IDLE) && (req != 2'b00);

  arb_pick_2 u_pick (
    .req        (req),
    .last_grant (last_grant),
    .winner     (winner)
  );

`ifdef AXI_RD_ARB_RR_EN
  // Reset to LSU so the IFU wins the first contended cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= MID_LSU;
    end else if (grant) begin
      last_grant <= winner;
    end
  end
`else
  assign last_grant = MID_IFU;
`endif

  // The address is captured at grant so a requester dropping arvalid
  // afterwards cannot disturb the memory-side AR channel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      owner     <= MID_IFU;
      s_arvalid <= 1'b0;
      s_araddr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner     <= winner;
            s_araddr  <= (winner == MID_LSU) ? m1_araddr : m0_araddr;
            s_arvalid <= 1'b1;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (s_arready) begin
            s_arvalid <= 1'b0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (s_rvalid && s_rready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          s_arvalid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_addr = (state == ST_ADDR);
  assign in_data = (state == ST_DATA);

  // Handshake signals are routed only to the owner; everything is gated by
  // state so reset silences them in the same instant.
  assign m0_arready = in_addr && (owner == MID_IFU) && s_arready;
  assign m1_arready = in_addr && (owner == MID_LSU) && s_arready;

  assign m0_rvalid  = in_data && (owner == MID_IFU) && s_rvalid;
  assign m1_rvalid  = in_data && (owner == MID_LSU) && s_rvalid;

  assign s_rready   = in_data && ((owner == MID_LSU) ? m1_rready : m0_rready);

  // Both masters see the response payload while a read is in its data phase.
  assign m0_rdata   = in_data ? s_rdata : '0;
  assign m1_rdata   = in_data ? s_rdata : '0;
  assign m0_rresp   = in_data ? s_rresp : RRESP_OKAY;
  assign m1_rresp   = in_data ? s_rresp : RRESP_OKAY;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] m1_araddr, m1_rdata;
  logic [1:0]  m1_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [1:0]  s_rresp;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: at most one read in flight, described by who owns it,
  // its address and whether the address has been accepted yet.
  bit          busy, aphase, own, lg;
  logic [31:0] taddr;
  int          completions;
  int          cyc;
  int          rv0_cyc;
  int          rhs0_count;
  logic [31:0] grant_log[$];
  bit          prev_arvalid;
  bit          hs0, hs1, rhs0, rhs1;

  function automatic bit pick(input bit r0, input bit r1);
`ifdef AXI_RD_ARB_RR_EN
    if (r0 && r1) return !lg;
`endif
    return r1;
  endfunction

  task automatic reset_model();
    busy = 0; aphase = 0; own = 0; lg = 1; prev_arvalid = 0;
  endtask

  task automatic idle_inputs();
    m0_arvalid = 0; m0_araddr = '0; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = '0; m1_rready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = 2'b00;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_s_arvalid", s_arvalid, 0);
    check_eq("rst_s_araddr", s_araddr, 0);
    check_eq("rst_s_rready", s_rready, 0);
    check_eq("rst_m0_arready", m0_arready, 0);
    check_eq("rst_m1_arready", m1_arready, 0);
    check_eq("rst_m0_rvalid", m0_rvalid, 0);
    check_eq("rst_m1_rvalid", m1_rvalid, 0);
  endtask

  // Called at a falling edge with inputs already driven: checks the outputs
  // against the model, advances the model across the next rising edge and
  // returns at the following falling edge.
  task automatic cycle();
    bit ro;
    #1;
    if (s_arvalid && !prev_arvalid) grant_log.push_back(s_araddr);
    prev_arvalid = s_arvalid;
    hs0  = m0_arvalid && m0_arready;
    hs1  = m1_arvalid && m1_arready;
    rhs0 = m0_rvalid && m0_rready;
    rhs1 = m1_rvalid && m1_rready;
    if (rhs0) begin rv0_cyc = cyc; rhs0_count++; end
    ro = own ? m1_rready : m0_rready;
    check_eq("s_arvalid", s_arvalid, busy && aphase);
    if (busy && aphase) check_eq("s_araddr", s_araddr, taddr);
    check_eq("m0_arready", m0_arready, busy && aphase && !own && s_arready);
    check_eq("m1_arready", m1_arready, busy && aphase && own && s_arready);
    check_eq("m0_rvalid", m0_rvalid, busy && !aphase && !own && s_rvalid);
    check_eq("m1_rvalid", m1_rvalid, busy && !aphase && own && s_rvalid);
    check_eq("s_rready", s_rready, busy && !aphase && ro);
    if (busy && !aphase) begin
      check_eq("m0_rpayload", {m0_rresp, m0_rdata}, {s_rresp, s_rdata});
      check_eq("m1_rpayload", {m1_rresp, m1_rdata}, {s_rresp, s_rdata});
    end
    if (!busy) begin
      if (m0_arvalid || m1_arvalid) begin
        own = pick(m0_arvalid, m1_arvalid);
        lg = own;
        taddr = own ? m1_araddr : m0_araddr;
        busy = 1;
        aphase = 1;
      end
    end else if (aphase) begin
      if (s_arready) aphase = 0;
    end else if (s_rvalid && ro) begin
      busy = 0;
      completions++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    m0_arvalid = 0; m1_arvalid = 0;
    s_arready = 1; s_rvalid = 1; m0_rready = 1; m1_rready = 1;
    for (int i = 0; i < 20 && busy; i++) cycle();
    check_eq(tag, busy, 0);
  endtask

  logic [31:0] exp_first, exp_second, g;
  int          c0, r0, start;
  bit          pend0, pend1, wait0, wait1;

  initial begin
    idle_inputs();
    reset_model();
    completions = 0; cyc = 0; rhs0_count = 0; rv0_cyc = -1;
    @(negedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    resetn = 1;

    // Tie from a fresh reset.
`ifdef AXI_RD_ARB_RR_EN
    exp_first = 32'h8000_0004; exp_second = 32'h8000_1000;
`else
    exp_first = 32'h8000_1000; exp_second = 32'h8000_0004;
`endif
    grant_log.delete();
    m0_arvalid = 1; m0_araddr = 32'h8000_0004;
    m1_arvalid = 1; m1_araddr = 32'h8000_1000;
    s_arready = 1; s_rvalid = 1; s_rdata = 32'h1234_5678; m0_rready = 1; m1_rready = 1;
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (hs1) m1_arvalid = 0;
    end
    g = (grant_log.size() > 0) ? grant_log[0] : 'x;
    check_eq("tie_first_grant", g, exp_first);
    g = (grant_log.size() > 1) ? grant_log[1] : 'x;
    check_eq("tie_second_grant", g, exp_second);
    drain("tie_drain");

    // IFU alone, memory answering at once.
    grant_log.delete();
    c0 = completions; start = cyc; rv0_cyc = -1;
    m0_arvalid = 1; m0_araddr = 32'h8000_0000;
    s_arready = 1; s_rvalid = 1; s_rdata = 32'h0000_0413; s_rresp = 2'b00;
    m0_rready = 1; m1_rready = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (hs0) m0_arvalid = 0;
    end
    g = (grant_log.size() > 0) ? grant_log[0] : 'x;
    check_eq("ifu_addr", g, 32'h8000_0000);
    check_eq("ifu_rvalid_cycle", rv0_cyc - start, 2);
    check_eq("ifu_one_read", completions - c0, 1);

    // Stray memory response while idle.
    c0 = completions;
    idle_inputs();
    s_rvalid = 1; m0_rready = 1; m1_rready = 1;
    repeat (2) cycle();
    check_eq("stray_rvalid_ignored", completions - c0, 0);

    // Requester drops arvalid after grant while memory stalls.
    c0 = completions; r0 = rhs0_count;
    idle_inputs();
    m0_arvalid = 1; m0_araddr = 32'h8000_00C0;
    cycle();
    m0_arvalid = 0;
    repeat (3) cycle();
    s_arready = 1;
    cycle();
    s_arready = 0; s_rvalid = 1; s_rdata = 32'h0000_CAFE; m0_rready = 1;
    cycle();
    check_eq("drop_one_read", completions - c0, 1);
    check_eq("drop_data_to_m0", rhs0_count - r0, 1);

    // Asynchronous reset in the data phase, with a new IFU request pending.
    idle_inputs();
    m0_arvalid = 1; m0_araddr = 32'h8000_0040; s_arready = 1;
    cycle();
    cycle();
    m0_araddr = 32'h8000_0080; s_rvalid = 1; m0_rready = 0;
    #2 check_eq("pre_rst_m0_rvalid", m0_rvalid, 1);
    resetn = 0;
    #1 check_reset_outputs();
    reset_model();
    @(negedge clk);
    resetn = 1;
    grant_log.delete();
    c0 = completions;
    m0_rready = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (hs0) m0_arvalid = 0;
    end
    g = (grant_log.size() > 0) ? grant_log[0] : 'x;
    check_eq("post_rst_grant", g, 32'h8000_0080);
    check_eq("post_rst_read", completions - c0, 1);
    drain("post_rst_drain");

    // Randomized traffic: each master keeps one request in flight, holds
    // arvalid until accepted, and now and then withdraws it.
    c0 = completions;
    pend0 = 0; pend1 = 0; wait0 = 0; wait1 = 0;
    hs0 = 0; hs1 = 0; rhs0 = 0; rhs1 = 0;
    for (int n = 0; n < 3000; n++) begin
      if (hs0) begin pend0 = 0; wait0 = 1; end
      if (rhs0) wait0 = 0;
      if (hs1) begin pend1 = 0; wait1 = 1; end
      if (rhs1) wait1 = 0;
      if (!pend0 && !wait0 && $urandom_range(2) == 0) begin
        pend0 = 1; m0_araddr = $urandom;
      end else if (pend0 && $urandom_range(49) == 0) begin
        pend0 = 0;
      end
      if (!pend1 && !wait1 && $urandom_range(2) == 0) begin
        pend1 = 1; m1_araddr = $urandom;
      end else if (pend1 && $urandom_range(49) == 0) begin
        pend1 = 0;
      end
      m0_arvalid = pend0;
      m1_arvalid = pend1;
      m0_rready  = ($urandom_range(3) != 0);
      m1_rready  = ($urandom_range(3) != 0);
      s_arready  = ($urandom_range(2) != 0);
      s_rvalid   = ($urandom_range(2) != 0);
      s_rdata    = $urandom;
      s_rresp    = ($urandom_range(1) == 0) ? 2'b00 : 2'b10;
      cycle();
    end
    check_eq("random_progress", (completions - c0) > 200, 1);
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
